// File: rtl/pcmcia_host.sv
// PCMCIA host bus master: turns single-byte requests into timed card cycles
// (common/attribute memory and I/O), honours card WAIT with a timeout, and
// returns read data, error and INPACK status as a one-cycle response pulse.
// All card-side outputs are registered and lag the FSM state by one cycle.
module pcmcia_host #(
  parameter int T_SETUP      = 3,
  parameter int T_STROBE     = 8,
  parameter int T_HOLD       = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_space,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_inpack,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        CE1,
  output logic        CE2,
  output logic        REG,
  output logic        OE,
  output logic        WE,
  output logic        IORD,
  output logic        IOWR,
  input  logic        WAIT,
  input  logic        INPACK
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITX, HOLD, DONE} state_t;

  // Terminal counts: every phase counter starts at 0 on state entry.
  localparam logic [7:0] SETUP_LAST   = 8'(T_SETUP - 1);
  localparam logic [7:0] STROBE_LAST  = 8'(T_STROBE - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(T_HOLD - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        lat_write;
  logic [1:0]  lat_space;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic [1:0]  sync_wait;
  logic [1:0]  sync_inpack;
  logic        wait_s;
  logic        inpack_s;
  logic        is_io;
  logic        reg_sel;
  logic [7:0]  cap_rdata;
  logic        cap_inpack;

  assign wait_s     = sync_wait[1];
  assign inpack_s   = sync_inpack[1];
  assign is_io      = (lat_space == 2'd2);
  assign reg_sel    = (lat_space == 2'd1) || (lat_space == 2'd2);
  // Values captured when the strobe completes: writes report 0x00 and only
  // I/O reads report INPACK (active low on the card side).
  assign cap_rdata  = lat_write ? 8'h00 : D_in;
  assign cap_inpack = is_io & ~lat_write & ~inpack_s;

  // Two-flop synchronizers for the asynchronous card status inputs (idle high).
  // NOTE: sequential blocks use only non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_wait   <= 2'b11;
      sync_inpack <= 2'b11;
    end else begin
      sync_wait   <= {sync_wait[0], WAIT};
      sync_inpack <= {sync_inpack[0], INPACK};
    end
  end

  // Cycle FSM with registered bus outputs driven from the current state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      // NOTE: the latched request is reset too so nothing downstream ever
      // sees X before the first acceptance.
      lat_write  <= 1'b0;
      lat_space  <= 2'd0;
      lat_addr   <= 16'h0000;
      lat_wdata  <= 8'h00;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_err    <= 1'b0;
      rsp_inpack <= 1'b0;
      A          <= 16'h0000;
      D_out      <= 8'h00;
      D_oe       <= 1'b0;
      CE1        <= 1'b1;
      CE2        <= 1'b1;
      REG        <= 1'b1;
      OE         <= 1'b1;
      WE         <= 1'b1;
      IORD       <= 1'b1;
      IOWR       <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      req_ready <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            lat_write  <= req_write;
            lat_space  <= req_space;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            cnt        <= 8'd0;
            rsp_inpack <= 1'b0;
            if (req_space == 2'd3) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 8'hFF;
              state     <= DONE;
            end else begin
              rsp_err   <= 1'b0;
              rsp_rdata <= 8'h00;
              state     <= SETUP;
            end
          end
        end
        SETUP: begin
          A     <= lat_addr;
          CE1   <= 1'b0;
          CE2   <= 1'b1;
          REG   <= ~reg_sel;
          D_out <= lat_write ? lat_wdata : 8'h00;
          D_oe  <= lat_write;
          if (cnt == SETUP_LAST) begin
            cnt   <= 8'd0;
            state <= STROBE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STROBE, WAITX: begin
          OE   <= is_io | lat_write;
          WE   <= is_io | ~lat_write;
          IORD <= ~is_io | lat_write;
          IOWR <= ~is_io | ~lat_write;
          if (state == STROBE) begin
            if (cnt == STROBE_LAST) begin
              cnt <= 8'd0;
              if (!wait_s) begin
                state <= WAITX;
              end else begin
                rsp_rdata  <= cap_rdata;
                rsp_inpack <= cap_inpack;
                state      <= HOLD;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else if (wait_s) begin
            cnt        <= 8'd0;
            rsp_rdata  <= cap_rdata;
            rsp_inpack <= cap_inpack;
            state      <= HOLD;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt        <= 8'd0;
            rsp_err    <= 1'b1;
            rsp_rdata  <= 8'hFF;
            rsp_inpack <= 1'b0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          OE   <= 1'b1;
          WE   <= 1'b1;
          IORD <= 1'b1;
          IOWR <= 1'b1;
          if (cnt == HOLD_LAST) begin
            cnt   <= 8'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
          CE1       <= 1'b1;
          CE2       <= 1'b1;
          REG       <= 1'b1;
          D_oe      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcmcia_host.sv
// Self-checking bench for pcmcia_host: per-scenario tasks check bus timing
// inline; a scoreboard queue holds expected responses and latencies that a
// negedge monitor compares against every rsp_valid pulse.
module tb_pcmcia_host;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_space = 2'd0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_inpack;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [7:0]  D_in = 8'h00;
  logic        CE1, CE2, REG, OE, WE, IORD, IOWR;
  logic        WAIT = 1'b1;
  logic        INPACK = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       inpack;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sb[$];

  pcmcia_host dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_space(req_space), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_inpack(rsp_inpack),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .CE1(CE1), .CE2(CE2), .REG(REG), .OE(OE), .WE(WE), .IORD(IORD), .IOWR(IOWR),
    .WAIT(WAIT), .INPACK(INPACK)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Response monitor: every pulse must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RESET && rsp_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, expected no response", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rsp_rdata, rsp_err, rsp_inpack} !== {e.rdata, e.err, e.inpack}) begin
          n_bad++;
          $display("FAIL rsp_fields: got rdata=%h err=%b inpack=%b, expected rdata=%h err=%b inpack=%b",
                   rsp_rdata, rsp_err, rsp_inpack, e.rdata, e.err, e.inpack);
        end
        n_cmp++;
        if (cyc - e.acc !== e.lat) begin
          n_bad++;
          $display("FAIL rsp_latency: got %0d cycles, expected %0d", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, optionally push expectation.
  task automatic issue(input logic wr, input logic [1:0] sp, input logic [15:0] ad,
                       input logic [7:0] wd, input logic [7:0] e_rdata, input logic e_err,
                       input logic e_inpack, input int e_lat, input bit track,
                       output int acc);
    bit got;
    exp_t e;
    got = 0;
    acc = -1000;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      req_write = wr;
      req_space = sp;
      req_addr  = ad;
      req_wdata = wd;
      req_valid = 1'b1;
      if (req_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL accept: req_ready never 1 within 60 cycles, expected acceptance");
      req_valid = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      acc = cyc;
      req_valid = 1'b0;
      req_write = $urandom_range(0, 1);
      req_space = 2'($urandom_range(0, 3));
      req_addr  = 16'($urandom);
      req_wdata = 8'($urandom);
      if (track) begin
        e.rdata = e_rdata; e.err = e_err; e.inpack = e_inpack; e.acc = acc; e.lat = e_lat;
        sb.push_back(e);
      end
    end
  endtask

  // Bounded wait for all expected responses to drain.
  task automatic wait_rsp(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL rsp_missing: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, rsp_inpack, D_oe, CE1, CE2, REG, OE, WE, IORD, IOWR}
        !== 12'b0000_0111_1111) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b, expected %b",
               {req_ready, rsp_valid, rsp_err, rsp_inpack, D_oe, CE1, CE2, REG, OE, WE, IORD, IOWR},
               12'b0000_0111_1111);
    end
    n_cmp++;
    if ({A, D_out, rsp_rdata} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got A=%h D_out=%h rdata=%h, expected all 0", A, D_out, rsp_rdata);
    end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_before_edge: got %b, expected 0", req_ready);
    end
    @(negedge CLK);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_edge: got %b, expected 1", req_ready);
    end
  endtask

  task automatic test_mem_read();
    int acc;
    logic [6:0] exp_v;
    D_in = 8'h5A;
    issue(1'b0, 2'd0, 16'h0123, 8'h00, 8'h5A, 1'b0, 1'b0, 14, 1, acc);
    for (int k = 0; k <= 14; k++) begin
      @(negedge CLK);
      // {CE1, REG, OE, WE, IORD, IOWR, D_oe}
      exp_v = {!(k >= 1 && k <= 13), 1'b1, !(k >= 4 && k <= 11), 1'b1, 1'b1, 1'b1, 1'b0};
      n_cmp++;
      if ({CE1, REG, OE, WE, IORD, IOWR, D_oe} !== exp_v) begin
        n_bad++;
        $display("FAIL mem_read_bus c%0d: got %b, expected %b", k,
                 {CE1, REG, OE, WE, IORD, IOWR, D_oe}, exp_v);
      end
      if (k == 2) begin
        n_cmp++;
        if ({A, CE2} !== {16'h0123, 1'b1}) begin
          n_bad++;
          $display("FAIL mem_read_addr: got A=%h CE2=%b, expected A=0123 CE2=1", A, CE2);
        end
      end
    end
    wait_rsp(20);
  endtask

  task automatic test_attr_write();
    int acc;
    logic [6:0] exp_v;
    issue(1'b1, 2'd1, 16'h0200, 8'hC3, 8'h00, 1'b0, 1'b0, 14, 1, acc);
    for (int k = 0; k <= 14; k++) begin
      @(negedge CLK);
      exp_v = {!(k >= 1 && k <= 13), !(k >= 1 && k <= 13), 1'b1, !(k >= 4 && k <= 11),
               1'b1, 1'b1, (k >= 1 && k <= 13)};
      n_cmp++;
      if ({CE1, REG, OE, WE, IORD, IOWR, D_oe} !== exp_v) begin
        n_bad++;
        $display("FAIL attr_write_bus c%0d: got %b, expected %b", k,
                 {CE1, REG, OE, WE, IORD, IOWR, D_oe}, exp_v);
      end
      if (k == 5) begin
        n_cmp++;
        if ({A, D_out} !== {16'h0200, 8'hC3}) begin
          n_bad++;
          $display("FAIL attr_write_data: got A=%h D_out=%h, expected A=0200 D_out=c3", A, D_out);
        end
      end
    end
    wait_rsp(20);
  endtask

  task automatic test_io_read_wait();
    int acc;
    logic [6:0] exp_v;
    D_in = 8'h81;
    INPACK = 1'b0;
    // Card holds WAIT low long enough for exactly five WAITX cycles.
    issue(1'b0, 2'd2, 16'h0040, 8'h00, 8'h81, 1'b0, 1'b1, 19, 1, acc);
    for (int k = 0; k <= 19; k++) begin
      @(negedge CLK);
      exp_v = {!(k >= 1 && k <= 18), !(k >= 1 && k <= 18), 1'b1, 1'b1,
               !(k >= 4 && k <= 16), 1'b1, 1'b0};
      n_cmp++;
      if ({CE1, REG, OE, WE, IORD, IOWR, D_oe} !== exp_v) begin
        n_bad++;
        $display("FAIL io_read_bus c%0d: got %b, expected %b", k,
                 {CE1, REG, OE, WE, IORD, IOWR, D_oe}, exp_v);
      end
      WAIT = !(k >= 3 && k <= 12);
    end
    WAIT = 1'b1;
    INPACK = 1'b1;
    wait_rsp(20);
  endtask

  task automatic test_timeout();
    int acc;
    int first_low;
    int last_low;
    first_low = -1;
    last_low = -1;
    WAIT = 1'b0;
    issue(1'b0, 2'd0, 16'h0777, 8'h00, 8'hFF, 1'b1, 1'b0, 269, 1, acc);
    for (int k = 0; k <= 270; k++) begin
      @(negedge CLK);
      if (OE === 1'b0) begin
        if (first_low < 0) first_low = k;
        last_low = k;
      end
    end
    WAIT = 1'b1;
    n_cmp++;
    if (first_low !== 4 || last_low !== 266) begin
      n_bad++;
      $display("FAIL timeout_strobe: OE low c%0d..c%0d, expected c4..c266", first_low, last_low);
    end
    wait_rsp(20);
    n_cmp++;
    if ({req_ready, OE, CE1} !== 3'b111) begin
      n_bad++;
      $display("FAIL timeout_idle: got ready/OE/CE1=%b, expected 111", {req_ready, OE, CE1});
    end
  endtask

  task automatic test_reserved();
    int acc;
    issue(1'b0, 2'd3, 16'h1234, 8'h00, 8'hFF, 1'b1, 1'b0, 1, 1, acc);
    for (int k = 0; k <= 3; k++) begin
      @(negedge CLK);
      n_cmp++;
      if ({CE1, CE2, REG, OE, WE, IORD, IOWR, D_oe} !== 8'b1111_1110) begin
        n_bad++;
        $display("FAIL reserved_bus c%0d: got %b, expected 11111110", k,
                 {CE1, CE2, REG, OE, WE, IORD, IOWR, D_oe});
      end
    end
    wait_rsp(10);
  endtask

  task automatic test_reset_mid();
    int acc;
    D_in = 8'h3C;
    issue(1'b0, 2'd0, 16'h0100, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0, acc);
    for (int k = 0; k <= 6; k++) @(negedge CLK);
    n_cmp++;
    if ({OE, CE1} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_strobe_active: got OE/CE1=%b, expected 00", {OE, CE1});
    end
    #1 RESET = 1'b1;
    #1;
    n_cmp++;
    if ({OE, CE1, CE2, REG, req_ready, rsp_valid} !== 6'b111100) begin
      n_bad++;
      $display("FAIL mid_reset_async: got %b, expected 111100",
               {OE, CE1, CE2, REG, req_ready, rsp_valid});
    end
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_reset_no_rsp: got rsp_valid=%b, expected 0", rsp_valid);
      end
    end
    issue(1'b1, 2'd2, 16'h0010, 8'h99, 8'h00, 1'b0, 1'b0, 14, 1, acc);
    for (int k = 0; k <= 14; k++) begin
      @(negedge CLK);
      n_cmp++;
      if ({OE, WE, IORD, IOWR, D_oe} !== {3'b111, !(k >= 4 && k <= 11), (k >= 1 && k <= 13)}) begin
        n_bad++;
        $display("FAIL post_reset_iowr c%0d: got %b, expected %b", k, {OE, WE, IORD, IOWR, D_oe},
                 {3'b111, !(k >= 4 && k <= 11), (k >= 1 && k <= 13)});
      end
    end
    wait_rsp(20);
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    D_in = 8'hA7;
    issue(1'b1, 2'd0, 16'hBEEF, 8'h5C, 8'h00, 1'b0, 1'b0, 14, 1, acc1);
    // Busy-time request traffic must not disturb the cycle in flight.
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_space = 2'd2;
      req_addr  = 16'h0F0F;
      req_wdata = 8'h11;
    end
    n_cmp++;
    if ({A, D_out, WE, OE, D_oe} !== {16'hBEEF, 8'h5C, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL busy_ignore: got A=%h D_out=%h WE=%b OE=%b D_oe=%b, expected BEEF 5c 0 1 1",
               A, D_out, WE, OE, D_oe);
    end
    req_valid = 1'b0;
    issue(1'b0, 2'd0, 16'h00A0, 8'h00, 8'hA7, 1'b0, 1'b0, 14, 1, acc2);
    n_cmp++;
    if (acc2 - acc1 !== 15) begin
      n_bad++;
      $display("FAIL back_to_back_gap: got %0d cycles between acceptances, expected 15", acc2 - acc1);
    end
    wait_rsp(30);
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_attr_write();
    test_io_read_wait();
    test_timeout();
    test_reserved();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
